// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int              ADDR_W_DEF     = 8;
  localparam int              INSTR_W_DEF    = 16;
  localparam logic [15:0]     HALT_INSTR_DEF = 16'hFFFF;

endpackage

// File: rtl/fetch_if_id_reg.sv
// Generic pipeline register with a valid bit: load captures and sets valid.
// Flush clears valid but keeps the data, and flush wins over load.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem init strobe, INIT/FETCH/HALTED control, IF/ID hand-off.
// One-cycle fetch latency; the IF/ID register holds while decode stalls.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = ADDR_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 INIT_CYCLES = 1,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = INSTR_W'(HALT_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_init,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_next,
  output logic               halted
);

  localparam int         DAT_W     = INSTR_W + 2 * ADDR_W;
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [3:0]        r_init_cnt, w_init_cnt_nxt;
  logic              w_advance, w_load, w_flush;
  logic [DAT_W-1:0]  w_id_dat;

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_advance = !if_valid || if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_pc       <= RESET_PC;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Redirect outranks capture, stall and halt detection; INIT ignores it.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_init_cnt_nxt = r_init_cnt;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      INIT: begin
        w_init_cnt_nxt = r_init_cnt + 4'd1;
        if (r_init_cnt == INIT_LAST) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_target;
          w_flush  = 1'b1;
        end else if (w_advance) begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc_inc;
          if (imem_q == HALT_INSTR) w_state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_target;
          w_flush     = 1'b1;
          w_state_nxt = FETCH;
        end else if (if_valid && if_ready) begin
          w_flush = 1'b1;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_id_dat = {imem_q, r_pc, w_pc_inc};

  if_id_reg #(.W(DAT_W)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_dat   (w_id_dat),
    .o_vld   (if_valid),
    .o_dat   ({if_instr, if_pc, if_pc_next})
  );

  assign imem_addr = r_pc;
  assign imem_init = reset || (r_state == INIT);
  assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic        imem_init;
  logic [15:0] imem_q;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_next;
  logic        halted;

  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_q = mem[imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_init       (imem_init),
    .imem_q          (imem_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_next      (if_pc_next),
    .halted          (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [7:0] pc,
                        input logic [15:0] instr, input logic [7:0] pcn);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v));
    chk({tag, ".pc"}, 32'(if_pc), 32'(pc));
    chk({tag, ".instr"}, 32'(if_instr), 32'(instr));
    chk({tag, ".pc_next"}, 32'(if_pc_next), 32'(pcn));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h96C0;
    mem[1] = 16'h96C0;
    mem[2] = 16'hC806;
    mem[9] = 16'hFFFF;

    reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 8'h00;
    tick(); tick();
    chk_if("rst", 1'b0, 8'h00, 16'h0000, 8'h00);
    chk("rst.init", 32'(imem_init), 32'd1);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'h00);

    reset = 1'b0;
    #1;
    chk("init.after_rst", 32'(imem_init), 32'd1);
    redirect_valid = 1'b1; redirect_target = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("init.done", 32'(imem_init), 32'd0);
    chk("init.redir_ignored", 32'(imem_addr), 32'h00);
    chk("init.valid", 32'(if_valid), 32'd0);
    tick(); chk_if("f0", 1'b1, 8'h00, 16'h96C0, 8'h01);
    chk("f0.addr", 32'(imem_addr), 32'h01);
    tick(); chk_if("f1", 1'b1, 8'h01, 16'h96C0, 8'h02);
    tick(); chk_if("f2", 1'b1, 8'h02, 16'hC806, 8'h03);
    tick(); chk_if("f3", 1'b1, 8'h03, 16'h1003, 8'h04);
    tick(); chk_if("f4", 1'b1, 8'h04, 16'h1004, 8'h05);

    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_if("stall", 1'b1, 8'h04, 16'h1004, 8'h05);
      chk("stall.addr", 32'(imem_addr), 32'h05);
    end
    if_ready = 1'b1;
    tick(); chk_if("resume5", 1'b1, 8'h05, 16'h1005, 8'h06);
    tick(); chk_if("f6", 1'b1, 8'h06, 16'h1006, 8'h07);

    if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h0D;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    chk("redir.flush", 32'(if_valid), 32'd0);
    chk("redir.addr", 32'(imem_addr), 32'h0D);
    tick(); chk_if("redir.tgt", 1'b1, 8'h0D, 16'h100D, 8'h0E);

    redirect_valid = 1'b1; redirect_target = 8'h08;
    tick(); redirect_valid = 1'b0;
    chk("r8.flush", 32'(if_valid), 32'd0);
    tick(); chk_if("f8", 1'b1, 8'h08, 16'h1008, 8'h09);
    tick(); chk_if("halt", 1'b1, 8'h09, 16'hFFFF, 8'h0A);
    chk("halt.flag", 32'(halted), 32'd1);
    tick();
    chk("halt.drain", 32'(if_valid), 32'd0);
    chk("halt.pc_hold", 32'(imem_addr), 32'h0A);
    tick();
    chk("halt.nofetch", 32'(if_valid), 32'd0);
    chk("halt.stay", 32'(halted), 32'd1);

    redirect_valid = 1'b1; redirect_target = 8'h02;
    tick(); redirect_valid = 1'b0;
    chk("unhalt.flag", 32'(halted), 32'd0);
    chk("unhalt.valid", 32'(if_valid), 32'd0);
    tick(); chk_if("unhalt.tgt", 1'b1, 8'h02, 16'hC806, 8'h03);

    redirect_valid = 1'b1; redirect_target = 8'hFE;
    tick(); redirect_valid = 1'b0;
    chk("wrap.flush", 32'(if_valid), 32'd0);
    tick(); chk_if("wFE", 1'b1, 8'hFE, 16'h10FE, 8'hFF);
    tick(); chk_if("wFF", 1'b1, 8'hFF, 16'h10FF, 8'h00);
    tick(); chk_if("w00", 1'b1, 8'h00, 16'h96C0, 8'h01);
    tick(); chk_if("w01", 1'b1, 8'h01, 16'h96C0, 8'h02);

    reset = 1'b1; if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h30;
    tick();
    redirect_valid = 1'b0;
    chk_if("rst2", 1'b0, 8'h00, 16'h0000, 8'h00);
    chk("rst2.init", 32'(imem_init), 32'd1);
    chk("rst2.addr", 32'(imem_addr), 32'h00);
    chk("rst2.halted", 32'(halted), 32'd0);
    reset = 1'b0; if_ready = 1'b1;
    tick();
    chk("rst2.init_done", 32'(imem_init), 32'd0);
    chk("rst2.valid", 32'(if_valid), 32'd0);
    tick(); chk_if("rst2.f0", 1'b1, 8'h00, 16'h96C0, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined processor. Owns the program counter and drives the instruction memory's address and one-shot `init` load. Captures the 16-bit instruction returned in the same cycle into the IF/ID pipeline register and hands it to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and stops fetching after a HALT instruction.

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction-memory address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 8'd0: PC value after reset.
- `INIT_CYCLES`, 1: cycles `imem_init` stays high after reset deasserts (range 1–15).
- `HALT_INSTR`, 16'hFFFF: encoding that stops fetch.

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `imem_addr`  out  ADDR_W  instruction-memory address; combinationally equal to `pc`.
- `imem_init`  out  1  instruction-memory load strobe.
- `imem_q`  in  INSTR_W  memory read data; combinational from `imem_addr`, valid same cycle.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_target`  in  ADDR_W  new PC.
- `if_valid`  out  1  IF/ID register holds an instruction.
- `if_ready`  in  1  decode accepts the instruction this cycle.
- `if_instr`  out  INSTR_W  fetched instruction.
- `if_pc`  out  ADDR_W  address of `if_instr`.
- `if_pc_next`  out  ADDR_W  `if_pc + 1`, mod 2^ADDR_W.
- `halted`  out  1  high in HALTED state.

## Operation
- States: INIT, FETCH, HALTED.
- Reset values: state INIT, `pc = RESET_PC`, `init_cnt = 0`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `if_pc_next = 0`, `halted = 0`.
- `imem_init = reset | (state == INIT)`.
- INIT:
  - `init_cnt` increments each cycle.
  - Moves to FETCH in the cycle after `init_cnt == INIT_CYCLES-1`.
  - `redirect_valid` is ignored.
- FETCH:
  - `advance = !if_valid | if_ready`.
  - If `advance` and no redirect: `if_instr <= imem_q`, `if_pc <= pc`, `if_pc_next <= pc+1`, `if_valid <= 1`, `pc <= pc+1`.
  - If `imem_q == HALT_INSTR` is captured: move to HALTED. The HALT instruction is still presented downstream.
  - If `if_valid & !if_ready`: hold PC and the IF/ID register unchanged.
- HALTED:
  - No capture; PC holds.
  - `if_valid` clears on handshake (`if_valid & if_ready`).
- Redirect, in FETCH or HALTED: `pc <= redirect_target`, `if_valid <= 0` (the in-flight instruction is flushed regardless of `if_ready`), state moves to FETCH. Redirect has priority over capture, stall and halt detection.
- PC arithmetic is modulo 2^ADDR_W: 255 → 0, with no flag.
- Reset has priority over everything, including mid-redirect and mid-stall; INIT and the memory reload repeat in full.

## Timing
- Fetch latency: PC presented in cycle N; instruction appears on `if_instr` with `if_valid` in cycle N+1.
- Throughput: one instruction per cycle while `if_ready = 1`.
- First fetch from `RESET_PC` occurs in cycle INIT_CYCLES after reset deasserts. `if_valid` first rises one cycle later.
- Redirect penalty: redirect in cycle N flushes IF/ID. The instruction from the target is valid in cycle N+2 (one bubble).
- `if_*` outputs are registered. `imem_addr` is combinational from the `pc` register only, with no input-to-output path.
- Handshake: `if_instr`, `if_pc` and `if_pc_next` are stable while `if_valid & !if_ready`.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum {INIT, FETCH, HALTED}
  - `ADDR_W` and `INSTR_W` defaults
  - `HALT_INSTR` default
- One sub-module, `if_id_reg`: the IF/ID pipeline register with load/hold/flush controls and `valid`. Reusable for the later ID/EX register.
- The PC, init counter and FSM stay in `fetch_stage`.

## Test plan
- Reset 2 cycles, INIT_CYCLES=1, memory[0..2] = 16'h96C0, 16'h96C0, 16'hC806, `if_ready=1` → `imem_init` high through the cycle after reset. Then `if_pc` = 0, 1, 2 on consecutive cycles with the matching `if_instr`, `if_pc_next` = 1, 2, 3.
- Stream at PC=4, `if_ready=0` for 3 cycles → `if_instr`, `if_pc` and `imem_addr` frozen. Resume → PC 5 follows PC 4 with no skip or duplicate.
- Redirect to 8'h0D while stalled at PC=6 → `if_valid=0` next cycle. `if_pc=13` the cycle after; the instruction at 6 is never handed over.
- Memory[9] = 16'hFFFF → HALT presented with `if_pc=9`, `halted=1`, no further fetch. Redirect to 2 → `halted=0`, `if_pc=2` two cycles later.
- Redirect to 8'hFE, stream 4 instructions → `if_pc` = FE, FF, 00, 01, with `if_pc_next` at FF=00.
- Assert reset mid-stream with `if_valid=1` → next cycle all outputs at reset values, `imem_init=1`, and fetch restarts at `RESET_PC`.
